// File: rtl/rtc_pkg.sv
// Shared types and widths for the stopwatch control slice.
package rtc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } rtc_state_t;

  localparam int DBNC_W = 4;

endpackage

// File: rtl/rtc_debounce.sv
// Button front end: 2-flop synchronizer, tick-based debounce and press pulse.
module rtc_debounce
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic i_rtcclk,
  input  logic i_reset_n,
  input  logic i_basetick,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DBNC_W-1:0] TICKS_LAST = DBNC_W'(DEBOUNCE_TICKS - 1);

  logic [1:0]        sync_q;
  logic [DBNC_W-1:0] cnt_q;
  logic              level_q;
  logic              level_d1;
  logic              level_d2;
  logic              press_q;

  // The accepted level only moves after DEBOUNCE_TICKS ticks of a stable
  // disagreement; the press pulse is taken off a delayed copy of it.
  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      level_d1 <= 1'b0;
      level_d2 <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_btn};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (i_basetick) begin
        if (cnt_q == TICKS_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      level_d1 <= level_q;
      level_d2 <= level_d1;
      press_q  <= level_d1 & ~level_d2;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/rtc_controller.sv
// Stopwatch run/stop/lap sequencer driving the BCD counter chain and display latch.
module rtc_controller
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic       i_rtcclk,
  input  logic       i_reset_n,
  input  logic       i_basetick,
  input  logic       i_startstop,
  input  logic       i_lapreset,
  output logic       o_countenb,
  output logic       o_latchcount,
  output logic       o_countinit,
  output logic       o_displayhold,
  output logic [1:0] o_state
);

  logic       ss_press;
  logic       lr_press;
  rtc_state_t state_q;
  rtc_state_t state_next;
  logic       init_next;
  logic       countenb_q;
  logic       displayhold_q;
  logic       countinit_q;

  rtc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dbnc_ss (
    .i_rtcclk  (i_rtcclk),
    .i_reset_n (i_reset_n),
    .i_basetick(i_basetick),
    .i_btn     (i_startstop),
    .o_press   (ss_press)
  );

  rtc_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dbnc_lr (
    .i_rtcclk  (i_rtcclk),
    .i_reset_n (i_reset_n),
    .i_basetick(i_basetick),
    .i_btn     (i_lapreset),
    .o_press   (lr_press)
  );

  // Start/stop is checked first in every state, so a coincident lap/reset is dropped.
  always_comb begin
    state_next = state_q;
    init_next  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_press)      state_next = RUN;
        else if (lr_press) init_next  = 1'b1;
      end
      RUN: begin
        if (ss_press)      state_next = STOP;
        else if (lr_press) state_next = LAP;
      end
      LAP: begin
        if (ss_press)      state_next = STOP;
        else if (lr_press) state_next = RUN;
      end
      STOP: begin
        if (ss_press) begin
          state_next = RUN;
        end else if (lr_press) begin
          state_next = IDLE;
          init_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      countenb_q    <= 1'b0;
      displayhold_q <= 1'b0;
      countinit_q   <= 1'b0;
    end else begin
      state_q       <= state_next;
      countenb_q    <= (state_next == RUN) || (state_next == LAP);
      displayhold_q <= (state_next == LAP);
      countinit_q   <= init_next;
    end
  end

  assign o_countenb    = countenb_q;
  assign o_latchcount  = i_basetick & countenb_q;
  assign o_displayhold = displayhold_q;
  assign o_countinit   = countinit_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_rtc_controller.sv
// Directed bench for rtc_controller with DEBOUNCE_TICKS=2 and a tick every 10 clocks.
module tb_rtc_controller;

  logic       i_rtcclk;
  logic       i_reset_n;
  logic       i_basetick;
  logic       i_startstop;
  logic       i_lapreset;
  logic       o_countenb;
  logic       o_latchcount;
  logic       o_countinit;
  logic       o_displayhold;
  logic [1:0] o_state;

  int vectors     = 0;
  int miscompares = 0;
  int initPulses  = 0;
  int tickCnt     = 0;
  int initBase;

  rtc_controller #(.DEBOUNCE_TICKS(2)) dut (
    .i_rtcclk     (i_rtcclk),
    .i_reset_n    (i_reset_n),
    .i_basetick   (i_basetick),
    .i_startstop  (i_startstop),
    .i_lapreset   (i_lapreset),
    .o_countenb   (o_countenb),
    .o_latchcount (o_latchcount),
    .o_countinit  (o_countinit),
    .o_displayhold(o_displayhold),
    .o_state      (o_state)
  );

  initial begin
    i_rtcclk = 1'b0;
    forever #5 i_rtcclk = ~i_rtcclk;
  end

  // Base tick: one clock high out of every ten, changed just after posedge.
  initial begin
    i_basetick = 1'b0;
    forever begin
      @(posedge i_rtcclk);
      #1;
      tickCnt    = tickCnt + 1;
      i_basetick = (tickCnt % 10 == 0);
    end
  end

  always @(negedge i_rtcclk) begin
    if (o_countinit) initPulses <= initPulses + 1;
  end

  task automatic applyStimulus(input logic ss, input logic lr, input int cycles);
    i_startstop = ss;
    i_lapreset  = lr;
    repeat (cycles) @(negedge i_rtcclk);
  endtask

  task automatic pressButton(input logic ss, input logic lr);
    applyStimulus(ss, lr, 40);
    applyStimulus(1'b0, 1'b0, 40);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors = vectors + 1;
    assert (observed === expected)
    else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkLatch(input string tag, input logic running, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_rtcclk);
      checkOutput(tag, {7'd0, o_latchcount}, {7'd0, i_basetick & running});
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] st, input logic enb,
                            input logic hold);
    checkOutput({tag, "_state"}, {6'd0, o_state}, {6'd0, st});
    checkOutput({tag, "_countenb"}, {7'd0, o_countenb}, {7'd0, enb});
    checkOutput({tag, "_displayhold"}, {7'd0, o_displayhold}, {7'd0, hold});
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_startstop = 1'b0;
    i_lapreset  = 1'b0;
    repeat (3) @(negedge i_rtcclk);
    checkState("reset", 2'd0, 1'b0, 1'b0);
    checkOutput("reset_countinit", {7'd0, o_countinit}, 8'd0);
    checkOutput("reset_latchcount", {7'd0, o_latchcount}, 8'd0);
    i_reset_n = 1'b1;
    repeat (5) @(negedge i_rtcclk);

    $display("[TB] lap/reset in IDLE clears the counters");
    initBase = initPulses;
    pressButton(1'b0, 1'b1);
    checkState("idle_lr", 2'd0, 1'b0, 1'b0);
    checkOutput("idle_lr_init", 8'(initPulses - initBase), 8'd1);

    $display("[TB] start from IDLE");
    pressButton(1'b1, 1'b0);
    checkState("start", 2'd1, 1'b1, 1'b0);
    checkLatch("run_latch", 1'b1, 20);

    $display("[TB] one-tick glitch while running");
    while (i_basetick !== 1'b1) @(negedge i_rtcclk);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 40);
    checkState("glitch", 2'd1, 1'b1, 1'b0);

    $display("[TB] RUN -> LAP -> RUN");
    pressButton(1'b0, 1'b1);
    checkState("lap", 2'd3, 1'b1, 1'b1);
    checkLatch("lap_latch", 1'b1, 20);
    pressButton(1'b0, 1'b1);
    checkState("unlap", 2'd1, 1'b1, 1'b0);

    $display("[TB] RUN -> STOP -> IDLE");
    pressButton(1'b1, 1'b0);
    checkState("stop", 2'd2, 1'b0, 1'b0);
    checkLatch("stop_latch", 1'b0, 20);
    initBase = initPulses;
    pressButton(1'b0, 1'b1);
    checkState("clear", 2'd0, 1'b0, 1'b0);
    checkOutput("clear_init", 8'(initPulses - initBase), 8'd1);

    $display("[TB] simultaneous presses from RUN");
    pressButton(1'b1, 1'b0);
    checkState("restart", 2'd1, 1'b1, 1'b0);
    initBase = initPulses;
    pressButton(1'b1, 1'b1);
    checkState("both", 2'd2, 1'b0, 1'b0);
    checkOutput("both_init", 8'(initPulses - initBase), 8'd0);

    $display("[TB] reset during LAP with debounce in progress");
    pressButton(1'b1, 1'b0);
    pressButton(1'b0, 1'b1);
    checkState("lap2", 2'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 15);
    initBase  = initPulses;
    i_reset_n = 1'b0;
    #1;
    checkState("async_rst", 2'd0, 1'b0, 1'b0);
    checkOutput("async_rst_latch", {7'd0, o_latchcount}, 8'd0);
    checkOutput("async_rst_init", {7'd0, o_countinit}, 8'd0);
    applyStimulus(1'b0, 1'b0, 5);
    i_reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 60);
    checkState("post_rst", 2'd0, 1'b0, 1'b0);
    checkOutput("post_rst_init", 8'(initPulses - initBase), 8'd0);
    pressButton(1'b1, 1'b0);
    checkState("post_rst_start", 2'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
